ysyx_220066_alu_arb: RTL and testbench
======================================

# ysyx_220066_alu_arb

Two-port round-robin arbiter that shares the single 64-bit ALU between two requesters (e.g. execute-stage ops and a branch/address helper) using valid/ready handshakes. It drives the ALU operand and control inputs, captures the combinational ALU result and zero flag, and returns them to the winning requester through a one-entry response buffer per port. It sits between the issue logic and the ALU instance in the core.

## Interface
- XLEN, 64, operand/result width (fixed to the ALU width)
- CTR_W, 5, ALU control width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- reqN_valid  input  1  request valid, N∈{0,1}
- reqN_ready  output  1  request accepted this cycle when high with reqN_valid
- reqN_a / reqN_b  input  XLEN  operands A/B
- reqN_ctr  input  CTR_W  ALU control code
- rspN_valid  output  1  response buffer holds a result
- rspN_ready  input  1  requester consumes response
- rspN_result  output  XLEN  captured ALU result
- rspN_zero  output  1  captured ALU zero flag
- alu_a / alu_b  output  XLEN  to ALU operand inputs
- alu_ctr  output  CTR_W  to ALU control
- alu_result  input  XLEN  from ALU
- alu_zero  input  1  from ALU

## Operation
- Port N eligible: reqN_valid && slot free; slot free = !rspN_valid || rspN_ready (drain and refill in the same cycle allowed).
- Only one eligible port: it is granted, regardless of pointer.
- Both eligible: the port named by rr_ptr (1 bit) is granted.
- After any grant: rr_ptr <= ~granted port. No grant: rr_ptr holds.
- reqN_ready = grantN; at most one ready per cycle. Ready may depend combinationally on valids and rspN_ready; valid must not depend on ready.
- Granted request's a/b/ctr drive alu_*; with no grant alu_a=alu_b=0, alu_ctr=0.
- On the accepting edge: rspN_result <= alu_result, rspN_zero <= alu_zero, rspN_valid <= 1.
- rspN_valid clears on rspN_ready unless a new result is written on the same edge; while rspN_valid && !rspN_ready, result/zero stay stable.
- Responses per port return in request order (one outstanding per buffer).

## Timing
- Reset (async, rst_n low): rspN_valid=0, rspN_result=0, rspN_zero=0, rr_ptr=0 (port 0 wins first tie), pipeline stage cleared; in-flight ops dropped. reqN_ready=0 while in reset.
- Latency: accept on edge E -> rspN_valid high in the cycle after E (1 cycle).
- Throughput: 1 op/cycle total; a single port sustains 1 op/cycle if it drains every cycle.
- Tie every cycle: grants alternate 0,1,0,1…
- Full buffer (rspN_valid && !rspN_ready): port N not granted; other port still served.

## Configuration
- ALU_ARB_PIPE_EN defined: register stage between grant and ALU (alu_a/alu_b/alu_ctr registered, plus port tag and valid bit). Latency becomes 2 cycles (accept at E -> rspN_valid after E+1). Port N eligible only if no op for port N is in the stage and slot free; per-port throughput 1 op/2 cycles, aggregate 1/cycle when both ports alternate. Idle stage drives alu_* to 0.
- Not defined: combinational alu_* drive, 1-cycle latency as above.

## Test plan
- Reset: hold rst_n=0 mid-transaction -> all rspN_valid=0, reqN_ready=0; after release, first tie grants port 0.
- Single port: req0 a=3, b=4, ctr=5'h00 -> next cycle rsp0_valid=1, result=7, zero=0; req1 a=5, b=5, ctr=5'h08 -> rsp1 result=0, zero=1.
- Contention: both valid every cycle, rsp ready=1 -> grants alternate 0,1,0,1; results match per-port operands in order.
- Backpressure: rsp0_ready=0 with rsp0 full -> req0_ready=0, rsp0_result stable, port 1 still granted; raising rsp0_ready re-grants port 0 that same cycle.
- Drain+refill: rsp0_valid=1, rsp0_ready=1, req0 valid -> accepted same cycle, rsp0_valid stays 1 with new result.
- ALU_ARB_PIPE_EN: same single-port stimulus -> result valid 2 cycles after accept; back-to-back req0 accepted every other cycle.

Source files
------------

// File: rtl/ysyx_220066_alu_arb.sv
// rtl/ysyx_220066_alu_arb.sv - two-port round-robin arbiter sharing one 64-bit ALU
// Optional ALU_ARB_PIPE_EN inserts a register stage between grant and the ALU (2-cycle latency).
module ysyx_220066_alu_arb #(
    parameter int XLEN  = 64,
    parameter int CTR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [CTR_W-1:0] req0_ctr,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [XLEN-1:0]  rsp0_result,
    output logic             rsp0_zero,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [CTR_W-1:0] req1_ctr,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [XLEN-1:0]  rsp1_result,
    output logic             rsp1_zero,

    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [CTR_W-1:0] alu_ctr,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero
);

    logic             rr_ptr;
    logic             free0, free1;
    logic             elig0, elig1;
    logic             grant0, grant1;
    logic             wr0, wr1;
    logic [XLEN-1:0]  sel_a, sel_b;
    logic [CTR_W-1:0] sel_ctr;

    // A slot is free when empty or being drained on this edge.
    assign free0 = !rsp0_valid || rsp0_ready;
    assign free1 = !rsp1_valid || rsp1_ready;

`ifdef ALU_ARB_PIPE_EN
    logic             pipe_valid;
    logic             pipe_tag;
    logic [XLEN-1:0]  pipe_a, pipe_b;
    logic [CTR_W-1:0] pipe_ctr;

    assign elig0 = req0_valid && free0 && !(pipe_valid && !pipe_tag);
    assign elig1 = req1_valid && free1 && !(pipe_valid && pipe_tag);
`else
    assign elig0 = req0_valid && free0;
    assign elig1 = req1_valid && free1;
`endif

    // Reset gates the grants so no ready escapes while rst_n is low.
    assign grant0 = rst_n && elig0 && (!elig1 || !rr_ptr);
    assign grant1 = rst_n && elig1 && (!elig0 || rr_ptr);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_ctr = '0;
        if (grant0) begin
            sel_a   = req0_a;
            sel_b   = req0_b;
            sel_ctr = req0_ctr;
        end else if (grant1) begin
            sel_a   = req1_a;
            sel_b   = req1_b;
            sel_ctr = req1_ctr;
        end
    end

`ifdef ALU_ARB_PIPE_EN
    // Idle stage holds zeros because the selected operands are zero without a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= 1'b0;
            pipe_tag   <= 1'b0;
            pipe_a     <= '0;
            pipe_b     <= '0;
            pipe_ctr   <= '0;
        end else begin
            pipe_valid <= grant0 || grant1;
            pipe_tag   <= grant1;
            pipe_a     <= sel_a;
            pipe_b     <= sel_b;
            pipe_ctr   <= sel_ctr;
        end
    end

    assign alu_a   = pipe_a;
    assign alu_b   = pipe_b;
    assign alu_ctr = pipe_ctr;
    assign wr0     = pipe_valid && !pipe_tag;
    assign wr1     = pipe_valid && pipe_tag;
`else
    assign alu_a   = sel_a;
    assign alu_b   = sel_b;
    assign alu_ctr = sel_ctr;
    assign wr0     = grant0;
    assign wr1     = grant1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (grant0) begin
            rr_ptr <= 1'b1;
        end else if (grant1) begin
            rr_ptr <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
        end else if (wr0) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result;
            rsp0_zero   <= alu_zero;
        end else if (rsp0_ready) begin
            rsp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
        end else if (wr1) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result;
            rsp1_zero   <= alu_zero;
        end else if (rsp1_ready) begin
            rsp1_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_220066_alu_arb.sv
// tb/tb_ysyx_220066_alu_arb.sv - directed vector bench for ysyx_220066_alu_arb (default build)
module tb_ysyx_220066_alu_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_ctr, req1_ctr;
    logic        rsp0_valid, rsp0_ready, rsp0_zero;
    logic        rsp1_valid, rsp1_ready, rsp1_zero;
    logic [63:0] rsp0_result, rsp1_result;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_ctr;
    logic        alu_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_220066_alu_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctr(req0_ctr), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctr(req1_ctr), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Stand-in ALU: 0 = add, 8 = sub, anything else = xor.
    always_comb begin
        case (alu_ctr)
            5'h00:   alu_result = alu_a + alu_b;
            5'h08:   alu_result = alu_a - alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_result == 64'd0);
    end

    typedef struct {
        logic        v0;
        logic [63:0] a0, b0;
        logic [4:0]  c0;
        logic        v1;
        logic [63:0] a1, b1;
        logic [4:0]  c1;
        logic        rr0, rr1;
        logic        e_rdy0, e_rdy1;
        logic        e_v0;
        logic [63:0] e_r0;
        logic        e_z0;
        logic        e_v1;
        logic [63:0] e_r1;
        logic        e_z1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v0, input logic [63:0] a0, input logic [63:0] b0, input logic [4:0] c0,
                       input logic v1, input logic [63:0] a1, input logic [63:0] b1, input logic [4:0] c1,
                       input logic rr0, input logic rr1, input logic e_rdy0, input logic e_rdy1,
                       input logic e_v0, input logic [63:0] e_r0, input logic e_z0,
                       input logic e_v1, input logic [63:0] e_r1, input logic e_z1);
        vec_t t;
        t.v0 = v0; t.a0 = a0; t.b0 = b0; t.c0 = c0;
        t.v1 = v1; t.a1 = a1; t.b1 = b1; t.c1 = c1;
        t.rr0 = rr0; t.rr1 = rr1; t.e_rdy0 = e_rdy0; t.e_rdy1 = e_rdy1;
        t.e_v0 = e_v0; t.e_r0 = e_r0; t.e_z0 = e_z0;
        t.e_v1 = e_v1; t.e_r1 = e_r1; t.e_z1 = e_z1;
        vecs.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        req0_valid = t.v0; req0_a = t.a0; req0_b = t.b0; req0_ctr = t.c0;
        req1_valid = t.v1; req1_a = t.a1; req1_b = t.b1; req1_ctr = t.c1;
        rsp0_ready = t.rr0; rsp1_ready = t.rr1;
    endtask

    initial begin
        vec_t idle;
        logic exp_ptr;
        idle = '{default: '0};
        //   v0 a0  b0 c0    v1 a1 b1 c1    rr0 rr1 rdy0 rdy1 | v0 r0  z0 | v1 r1 z1
        add(0, 0,   0, 0,    0, 0, 0, 0,    1,  1,  0, 0,     0, 0,   0,  0, 0,  0); // idle
        add(1, 3,   4, 0,    0, 0, 0, 0,    1,  1,  1, 0,     1, 7,   0,  0, 0,  0); // single port 0
        add(0, 0,   0, 0,    1, 5, 5, 8,    1,  1,  0, 1,     0, 7,   0,  1, 0,  1); // single port 1, zero
        add(1, 10,  1, 0,    1, 20, 2, 0,   1,  1,  1, 0,     1, 11,  0,  0, 0,  1); // tie, ptr=0
        add(1, 10,  1, 0,    1, 20, 2, 0,   1,  1,  0, 1,     0, 11,  0,  1, 22, 0); // tie, ptr=1
        add(1, 30,  3, 8,    1, 7,  7, 0,   1,  1,  1, 0,     1, 27,  0,  0, 22, 0);
        add(1, 100, 1, 0,    1, 9,  9, 8,   1,  1,  0, 1,     0, 27,  0,  1, 0,  1);
        add(1, 1,   2, 0,    0, 0,  0, 0,   1,  1,  1, 0,     1, 3,   0,  0, 0,  1); // fill rsp0
        add(1, 5,   6, 0,    1, 40, 2, 0,   0,  1,  0, 1,     1, 3,   0,  1, 42, 0); // rsp0 full
        add(1, 5,   6, 0,    1, 1,  1, 8,   0,  1,  0, 1,     1, 3,   0,  1, 0,  1); // ptr=0 but blocked
        add(1, 5,   6, 0,    0, 0,  0, 0,   1,  1,  1, 0,     1, 11,  0,  0, 0,  1); // re-grant on ready
        add(1, 8,   8, 8,    0, 0,  0, 0,   1,  1,  1, 0,     1, 0,   1,  0, 0,  1); // drain+refill
        add(0, 0,   0, 0,    0, 0,  0, 0,   0,  0,  0, 0,     1, 0,   1,  0, 0,  1); // hold
        add(1, 1,   1, 0,    0, 0,  0, 0,   0,  0,  0, 0,     1, 0,   1,  0, 0,  1); // full, blocked
        add(0, 0,   0, 0,    0, 0,  0, 0,   1,  0,  0, 0,     0, 0,   1,  0, 0,  1); // drain

        rst_n = 1'b0;
        drive(idle);
        repeat (3) @(negedge clk);
        chk("reset_rsp0_valid", 64'(rsp0_valid), 64'd0);
        chk("reset_rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("reset_rsp0_result", rsp0_result, 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_req0_ready", i), 64'(req0_ready), 64'(vecs[i].e_rdy0));
            chk($sformatf("v%0d_req1_ready", i), 64'(req1_ready), 64'(vecs[i].e_rdy1));
            chk($sformatf("v%0d_alu_a", i), alu_a,
                vecs[i].e_rdy0 ? vecs[i].a0 : (vecs[i].e_rdy1 ? vecs[i].a1 : 64'd0));
            chk($sformatf("v%0d_alu_ctr", i), 64'(alu_ctr),
                vecs[i].e_rdy0 ? 64'(vecs[i].c0) : (vecs[i].e_rdy1 ? 64'(vecs[i].c1) : 64'd0));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rsp0_valid", i), 64'(rsp0_valid), 64'(vecs[i].e_v0));
            chk($sformatf("v%0d_rsp0_result", i), rsp0_result, vecs[i].e_r0);
            chk($sformatf("v%0d_rsp0_zero", i), 64'(rsp0_zero), 64'(vecs[i].e_z0));
            chk($sformatf("v%0d_rsp1_valid", i), 64'(rsp1_valid), 64'(vecs[i].e_v1));
            chk($sformatf("v%0d_rsp1_result", i), rsp1_result, vecs[i].e_r1);
            chk($sformatf("v%0d_rsp1_zero", i), 64'(rsp1_zero), 64'(vecs[i].e_z1));
        end

        // Sustained contention: last grant in the table was port 0, so port 1 wins next.
        exp_ptr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_a = 64'(k); req0_b = 64'd100; req0_ctr = 5'h00;
            req1_valid = 1'b1; req1_a = 64'(k); req1_b = 64'd200; req1_ctr = 5'h00;
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            #1;
            chk($sformatf("alt%0d_ready0", k), 64'(req0_ready), 64'(!exp_ptr));
            chk($sformatf("alt%0d_ready1", k), 64'(req1_ready), 64'(exp_ptr));
            @(posedge clk);
            #1;
            if (exp_ptr) chk($sformatf("alt%0d_rsp1", k), rsp1_result, 64'(k) + 64'd200);
            else         chk($sformatf("alt%0d_rsp0", k), rsp0_result, 64'(k) + 64'd100);
            exp_ptr = ~exp_ptr;
        end

        // Asynchronous reset in the middle of traffic.
        @(negedge clk);
        drive(idle);
        req0_valid = 1'b1; req0_a = 64'd3; req0_b = 64'd4;
        @(posedge clk);
        #1;
        chk("pre_reset_rsp0_valid", 64'(rsp0_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_rsp0_valid", 64'(rsp0_valid), 64'd0);
        chk("mid_reset_rsp0_result", rsp0_result, 64'd0);
        chk("mid_reset_req0_ready", 64'(req0_ready), 64'd0);
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 64'd9; req1_b = 64'd1;
        #1;
        chk("mid_reset_req1_ready", 64'(req1_ready), 64'd0);
        chk("mid_reset_alu_a", alu_a, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_tie_ready0", 64'(req0_ready), 64'd1);
        chk("post_reset_tie_ready1", 64'(req1_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("post_reset_rsp0_result", rsp0_result, 64'd7);
        chk("post_reset_rsp1_valid", 64'(rsp1_valid), 64'd0);
        @(negedge clk);
        drive(idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
